// File: rtl/mod_cnt_pkg.sv
// Shared constants and helpers for the modulo-N up/down counter family.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mod_cnt_pkg;

    // Direction encoding on the mode input.
    localparam logic MODE_UP   = 1'b1;
    localparam logic MODE_DOWN = 1'b0;

    // Bound behaviour encoding on the sat input.
    localparam logic BOUND_WRAP = 1'b0;
    localparam logic BOUND_SAT  = 1'b1;

    // Minimum counter width able to hold 0..modulus-1.
    // The reference model in the bench calls this too, so both sides
    // always size the count the same way.
    function automatic int cnt_width(input int modulus);
        return $clog2(modulus);
    endfunction

endpackage : mod_cnt_pkg

// File: rtl/mod_step.sv
// Single-step next-value generator for a modulo-N counter (up/down, wrap/saturate).
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether to use the result.
module mod_step
    import mod_cnt_pkg::*;
#(
    parameter int MODULUS = 12,
    parameter int WIDTH   = cnt_width(MODULUS)
) (
    input  logic [WIDTH-1:0] cur,
    input  logic             mode,
    input  logic             sat,
    output logic [WIDTH-1:0] nxt,
    output logic             wrap_evt
);

    // One extra bit of headroom so cur+1 cannot overflow silently when
    // MODULUS is an exact power of two.
    localparam logic [WIDTH:0] MAX_EXT  = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH:0] ZERO_EXT = '0;
    localparam logic [WIDTH:0] ONE_EXT  = (WIDTH+1)'(1);

    logic [WIDTH:0] cur_ext;
    logic [WIDTH:0] nxt_ext;
    logic           unused_top;

    assign cur_ext = {1'b0, cur};

    // Choose the neighbouring value in the requested direction, folding at
    // the bounds either by wrapping (flagging the event) or by holding.
    always_comb begin
        nxt_ext  = cur_ext;
        wrap_evt = 1'b0;
        if (mode == MODE_UP) begin
            if (cur_ext < MAX_EXT) begin
                nxt_ext = cur_ext + ONE_EXT;
            end else if (sat == BOUND_WRAP) begin
                nxt_ext  = ZERO_EXT;
                wrap_evt = 1'b1;
            end
        end else begin
            if (cur_ext > ZERO_EXT) begin
                nxt_ext = cur_ext - ONE_EXT;
            end else if (sat == BOUND_WRAP) begin
                nxt_ext  = MAX_EXT;
                wrap_evt = 1'b1;
            end
        end
    end

    // Result is always within 0..MODULUS-1, so the headroom bit is zero.
    assign nxt        = nxt_ext[WIDTH-1:0];
    assign unused_top = nxt_ext[WIDTH];

endmodule : mod_step

// File: rtl/mod_n_updown_counter.sv
// Parametrised modulo-N up/down counter with enable, wrap/saturate, tc, wrap and load-error pulses.
// Latency: one clock from reset/load/enable sampled to data_out, wrap and load_err updated; tc is combinational.
// Backpressure: none; enable is a per-cycle advance request that is always honoured.
module mod_n_updown_counter
    import mod_cnt_pkg::*;
#(
    parameter int MODULUS   = 12,
    parameter int WIDTH     = cnt_width(MODULUS),
    parameter int RESET_VAL = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic             mode,
    input  logic             sat,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             tc,
    output logic             wrap,
    output logic             load_err
);

    // Elaboration-time parameter sanity.
    if (MODULUS < 2) begin : g_chk_modulus
        $error("mod_n_updown_counter: MODULUS must be >= 2");
    end
    if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_chk_reset_val
        $error("mod_n_updown_counter: RESET_VAL must lie in 0..MODULUS-1");
    end
    if ((64'd1 << WIDTH) < 64'(MODULUS)) begin : g_chk_width
        $error("mod_n_updown_counter: WIDTH too small for MODULUS");
    end

    localparam logic [WIDTH:0]   MOD_EXT   = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_CNT   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ZERO_CNT  = '0;
    localparam logic [WIDTH-1:0] RESET_CNT = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic             load_err_q, load_err_d;

    logic [WIDTH-1:0] step_nxt;
    logic             step_wrap;

    mod_step #(
        .MODULUS (MODULUS),
        .WIDTH   (WIDTH)
    ) u_step (
        .cur      (cnt_q),
        .mode     (mode),
        .sat      (sat),
        .nxt      (step_nxt),
        .wrap_evt (step_wrap)
    );

    // Next state by priority load > count > hold; pulses default low so
    // they last exactly one cycle unless the event repeats.
    always_comb begin
        cnt_d      = cnt_q;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        if (load) begin
            // Out-of-range loads are clamped to the top of the range so
            // the count never leaves 0..MODULUS-1.
            if ({1'b0, data_in} >= MOD_EXT) begin
                cnt_d      = MAX_CNT;
                load_err_d = 1'b1;
            end else begin
                cnt_d = data_in;
            end
        end else if (enable) begin
            cnt_d  = step_nxt;
            wrap_d = step_wrap;
        end
    end

    // State registers; synchronous reset overrides load and enable.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q      <= RESET_CNT;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    assign data_out = cnt_q;
    assign wrap     = wrap_q;
    assign load_err = load_err_q;

    // Terminal count follows mode combinationally; cascaded stages must
    // qualify it with enable or register it.
    assign tc = ((mode == MODE_UP)   && (cnt_q == MAX_CNT)) ||
                ((mode == MODE_DOWN) && (cnt_q == ZERO_CNT));

endmodule : mod_n_updown_counter

// File: doc/mod_n_updown_counter.md
# mod_n_updown_counter

Parametrised modulo-N up/down counter, successor to the fixed MOD-12 counter.
- Generalises the modulus and adds an enable, a wrap/saturate mode, a terminal-count output, a wrap event pulse and out-of-range load detection.
- Sits as a reusable timing/sequence counter in datapaths.
- Is the DUT for the next revision of the counter testbench environment (generator, driver, monitors, reference model, scoreboard).

## Interface
- MODULUS, 12, count range 0..MODULUS-1; legal values ≥ 2.
- WIDTH, $clog2(MODULUS), width of data_in/data_out; must satisfy 2**WIDTH ≥ MODULUS.
- RESET_VAL, 0, value loaded on reset; must be < MODULUS.
- clock  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  count enable; 1 = advance by one step this cycle.
- load  input  1  parallel load of data_in; independent of enable.
- mode  input  1  direction: 1 = up, 0 = down.
- sat  input  1  bound behaviour: 1 = saturate at bound, 0 = wrap modulo MODULUS.
- data_in  input  WIDTH  load value.
- data_out  output  WIDTH  current count, registered.
- tc  output  1  terminal count: (mode==1 && data_out==MODULUS-1) || (mode==0 && data_out==0); combinational from data_out and mode.
- wrap  output  1  registered one-cycle pulse: a wrap occurred on the previous edge.
- load_err  output  1  registered one-cycle pulse: the previous edge loaded an out-of-range value.

## Operation
- Priority per edge: reset > load > enable-count > hold.
- Reset: data_out=RESET_VAL, wrap=0, load_err=0; load and enable are ignored.
- Load, data_in < MODULUS: data_out=data_in, load_err=0.
- Load, data_in ≥ MODULUS: data_out=MODULUS-1 (clamped), load_err=1. Can only occur when 2**WIDTH > MODULUS.
- Load always clears wrap, regardless of data_in.
- Count, up, data_out < MODULUS-1: data_out+1, wrap=0.
- Count, up, data_out == MODULUS-1:
  - sat=0: data_out=0, wrap=1.
  - sat=1: data_out holds, wrap=0.
- Count, down, data_out > 0: data_out-1, wrap=0.
- Count, down, data_out == 0:
  - sat=0: data_out=MODULUS-1, wrap=1.
  - sat=1: data_out holds, wrap=0.
- Hold (no load, enable=0): data_out unchanged, wrap=0, load_err=0.
- Arithmetic is done at WIDTH+1 bits internally, so there is no silent overflow when MODULUS == 2**WIDTH.
- data_out never leaves 0..MODULUS-1.
- mode and sat may change on any cycle and take effect on that edge.
- No state machine beyond the count register and the two pulse flops.

## Timing
- Latency: one clock from enable/load/reset sampled to data_out updated.
- wrap and load_err are valid in the same cycle as the data_out value they describe, and last exactly one cycle unless the event repeats.
- tc responds combinationally to mode within the same cycle. Consumers cascading counters must register tc or AND it with enable.
- Cascade rule: the upper stage's enable = lower enable && lower tc; the upper stage advances on the same edge the lower stage wraps.
- Reset mid-count takes effect on the next edge even if load=1 or enable=1.
- Reset values: data_out=RESET_VAL, wrap=0, load_err=0; tc follows data_out and mode.

## Structure
- Package mod_cnt_pkg holds:
  - MODE_UP=1'b1, MODE_DOWN=1'b0;
  - BOUND_WRAP=1'b0, BOUND_SAT=1'b1;
  - a function cnt_width(modulus) returning $clog2(modulus), shared by RTL and the testbench reference model.
- One combinational sub-module, mod_step: inputs cur, mode, sat; outputs next value and wrap_evt. The top level holds the registers, priority and load clamp.
- Parameter checks (MODULUS ≥ 2, RESET_VAL < MODULUS, 2**WIDTH ≥ MODULUS) as elaboration-time assertions.

## Test plan
All scenarios use MODULUS=12 and WIDTH=4 unless stated.
- Reset, then enable=1, mode=1, sat=0 for 13 cycles -> data_out 1..11, 0, 1; wrap=1 only in the cycle data_out==0; tc=1 only while data_out==11.
- Reset, then enable=1, mode=0, sat=0 -> data_out=11, wrap=1 for one cycle; next edge gives 10, wrap=0; tc=1 at 0 before the first edge.
- load=1 with data_in=10, then mode=1, sat=1, enable=1 for 4 cycles -> data_out 10, 11, 11, 11; wrap never asserts; tc=1 from the 11 onward.
- load=1 with data_in=15 -> data_out=11, load_err=1 for one cycle. load=1 with data_in=5 and enable=0 -> data_out=5, load_err=0.
- Count up to 7, then reset=1 together with load=1, data_in=3 and enable=1 -> data_out=0, wrap=0, load_err=0 on that edge.
- MODULUS=16, WIDTH=4: count up from 15 -> data_out=0, wrap=1. Exhaustive load of 0..15 -> load_err never asserts.
